seq_mux: RTL and testbench
==========================

SEQ_MUX -- requirements
Module: seq_mux

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data channel.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter DWELL, default 3: cycles spent per channel in scan mode before sampling, legal range 1..255.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  block enable; 0 forces IDLE.
REQ-007 Port mode  input  1  0 = manual select, 1 = auto scan.
REQ-008 Port sel  input  SELW=$clog2(CHANNELS)  manual channel select.
REQ-009 Port din  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port out_ready  input  1  consumer accepts the held scan sample.
REQ-011 Port dout  output  WIDTH  registered selected data.
REQ-012 Port out_valid  output  1  dout/out_chan hold a valid sample.
REQ-013 Port out_chan  output  SELW  channel index that produced dout.

Function
REQ-014 The FSM SHALL have four states: IDLE, MANUAL, SCAN_WAIT and SCAN_HOLD.
REQ-015 Whenever en=0, the FSM SHALL go to IDLE on the next edge, clear out_valid and hold dout/out_chan.
REQ-016 From IDLE with en=1, the FSM SHALL go to MANUAL if mode=0, or to SCAN_WAIT if mode=1 with ptr=0 and dwell count=0.
REQ-017 In MANUAL, each cycle, with sel<CHANNELS, the block SHALL set dout<=din[sel], out_chan<=sel and out_valid<=1 (latency 1 cycle); out_ready is ignored.
REQ-018 In MANUAL with sel>=CHANNELS, the block SHALL set dout<=0, out_chan<=sel and out_valid<=0.
REQ-019 In SCAN_WAIT, the dwell counter SHALL increment each cycle; at count==DWELL-1 the block SHALL capture din[ptr] into dout, set out_chan<=ptr and out_valid<=1, then go to SCAN_HOLD.
REQ-020 With DWELL=1, the capture SHALL occur on the first SCAN_WAIT cycle.
REQ-021 In SCAN_HOLD, dout, out_chan and out_valid SHALL stay stable until out_ready=1; the scan stalls with no overwrite or drop.
REQ-022 In SCAN_HOLD with out_ready=1, the block SHALL clear out_valid, advance ptr (CHANNELS-1 wraps to 0), clear the counter and return to SCAN_WAIT.
REQ-023 A mode change while en=1 SHALL take effect on the next edge.
- Entering scan SHALL always restart at ptr=0, count=0.
- Leaving scan from SCAN_HOLD SHALL discard the pending sample (out_valid follows the MANUAL rules).
REQ-024 When en falls in the same cycle as out_ready=1 in SCAN_HOLD, en SHALL take priority: the FSM goes to IDLE and ptr does not advance.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set state=IDLE, dout=0, out_valid=0, out_chan=0, ptr=0 and count=0; rst overrides en, mode and out_ready, including mid-scan.

Configuration
REQ-026 With SEQ_MUX_PARITY_EN defined, the block SHALL add output dout_par (1 bit), even parity of the dout being loaded, registered alongside dout and reset to 0.
- Without the macro, the port and its logic SHALL be absent.

Structure
REQ-027 Package seq_mux_pkg SHALL hold the state enum (IDLE, MANUAL, SCAN_WAIT, SCAN_HOLD) and mode constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-028 The dwell counter SHALL be sub-module seq_mux_dwell with inputs clk, rst, clear and inc, and output done (count==DWELL-1), parameterised by DWELL.

Verification (WIDTH=8, CHANNELS=4, DWELL=3, din ch0..ch3 = AA, BB, CC, DD)
REQ-029 Manual: en=1, mode=0, sel=2 -> dout=CC, out_chan=2, out_valid=1 one cycle after sel is applied; sel=3 -> DD on the next cycle.
REQ-030 Manual out of range: CHANNELS=3, sel=3 -> dout=00, out_valid=0.
REQ-031 Scan: mode=1, out_ready=1 -> samples AA, BB, CC, DD, AA every 4 cycles (3 dwell + 1 hold), out_chan 0, 1, 2, 3, 0 (wrap).
REQ-032 Backpressure: out_ready=0 for 10 cycles at ch1 -> dout=BB and out_valid=1 stay stable throughout; after out_ready=1, ch2 (CC) appears 4 cycles later.
REQ-033 rst pulse during SCAN_HOLD of ch2 -> next cycle all outputs 0; re-enabling scan restarts at ch0 (AA).
REQ-034 Parity build: with SEQ_MUX_PARITY_EN, dout=BB -> dout_par=0 (even ones count); dout=AB -> dout_par=1.

Source files
------------

// File: rtl/seq_mux_pkg.sv
// Shared definitions for the sequencing multiplexer: FSM state encoding,
// mode constants and a helper that sizes the dwell counter.
package seq_mux_pkg;

  // Top-level controller states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MANUAL    = 2'd1,
    SCAN_WAIT = 2'd2,
    SCAN_HOLD = 2'd3
  } state_t;

  // Values of the mode input
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Counter width able to hold 0..dwell-1; never narrower than one bit so
  // that a dwell of one still gives a legal vector
  function automatic int unsigned dwell_width(input int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/seq_mux_dwell.sv
// Dwell counter for the scan sequencer. Counts cycles spent on the current
// channel and flags the last one (count == DWELL-1). clear wins over inc.
module seq_mux_dwell
  import seq_mux_pkg::*;
#(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int unsigned CW = dwell_width(DWELL);

  logic [CW-1:0] count;

  // Cycle counter: synchronous reset, clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == CW'(DWELL - 1));

endmodule

// File: rtl/seq_mux.sv
// Sequencing multiplexer. Selects one of CHANNELS packed input channels,
// either under direct control of sel (manual) or by stepping through all
// channels with a fixed dwell per channel (scan). Scan samples are held
// until the consumer raises out_ready, so nothing is overwritten or dropped.
// Optional feature: define SEQ_MUX_PARITY_EN to add a registered even-parity
// output dout_par that tracks dout.
module seq_mux
  import seq_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 3,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          dout,
  output logic                      out_valid,
  output logic [SELW-1:0]           out_chan
`ifdef SEQ_MUX_PARITY_EN
  ,
  output logic                      dout_par
`endif
);

  // Channel count widened by one bit so an all-ones sel can be compared
  localparam logic [SELW:0]   CHAN_COUNT = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_CHAN  = SELW'(CHANNELS - 1);

  state_t            state, state_d;
  logic [SELW-1:0]   ptr, ptr_d;
  logic [WIDTH-1:0]  dout_d;
  logic [SELW-1:0]   chan_d;
  logic              valid_d;
  logic              cnt_clear, cnt_inc, cnt_done;
  logic              sel_ok;
  logic [WIDTH-1:0]  chan [CHANNELS];

  // Unpack the flat input bus into an indexable channel array
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan[k] = din[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok = ({1'b0, sel} < CHAN_COUNT);

  seq_mux_dwell #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .done  (cnt_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and next-output logic. A mode change acts on the very next
  // edge: leaving scan performs a manual load at once (discarding any held
  // scan sample), entering scan always starts from channel 0 with a fresh
  // dwell count. Dropping en beats everything, including a pending accept.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    dout_d    = dout;
    chan_d    = out_chan;
    valid_d   = out_valid;
    cnt_clear = 1'b1;
    cnt_inc   = 1'b0;

    if (!en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ptr_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          valid_d = 1'b0;
          ptr_d   = '0;
          state_d = (mode == MODE_SCAN) ? SCAN_WAIT : MANUAL;
        end

        MANUAL, SCAN_WAIT, SCAN_HOLD: begin
          if (mode == MODE_MANUAL) begin
            state_d = MANUAL;
            ptr_d   = '0;
            chan_d  = sel;
            if (sel_ok) begin
              dout_d  = chan[sel];
              valid_d = 1'b1;
            end else begin
              dout_d  = '0;
              valid_d = 1'b0;
            end
          end else if (state == MANUAL) begin
            state_d = SCAN_WAIT;
            valid_d = 1'b0;
            ptr_d   = '0;
          end else if (state == SCAN_WAIT) begin
            cnt_inc   = 1'b1;
            cnt_clear = cnt_done;
            if (cnt_done) begin
              dout_d  = chan[ptr];
              chan_d  = ptr;
              valid_d = 1'b1;
              state_d = SCAN_HOLD;
            end
          end else begin
            if (out_ready) begin
              valid_d = 1'b0;
              ptr_d   = (ptr == LAST_CHAN) ? '0 : ptr + SELW'(1);
              state_d = SCAN_WAIT;
            end
          end
        end

        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // Output and scan-pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      dout      <= dout_d;
      out_chan  <= chan_d;
      out_valid <= valid_d;
      ptr       <= ptr_d;
    end
  end

`ifdef SEQ_MUX_PARITY_EN
  // Even parity of the value being loaded into dout, kept in step with it
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_par <= 1'b0;
    end else begin
      dout_par <= ^dout_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_mux.sv
// Self-checking bench for seq_mux. A 4-channel instance is checked in every
// mode; a 3-channel instance shares the controls to cover out-of-range sel.
// Expected values come from the channel data array and simple arithmetic on
// the dwell/hold timing (sample n appears DWELL + n*(DWELL+1) edges after
// scan entry, from channel n mod CHANNELS).
module tb_seq_mux;
  import seq_mux_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 3;

  logic        clk = 1'b0;
  logic        rst, en, mode, out_ready;
  logic [1:0]  sel;
  logic [31:0] din;
  logic [23:0] din3;
  logic [7:0]  dout, dout3;
  logic        out_valid, out_valid3;
  logic [1:0]  out_chan, out_chan3;
`ifdef SEQ_MUX_PARITY_EN
  logic        dout_par, dout_par3;
`endif

  logic [7:0]  chan_data [4];
  logic [7:0]  exp_dout;
  logic [1:0]  exp_chan;
  int          assert_count = 0;
  int          fail_count   = 0;

  assign din  = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
  assign din3 = {chan_data[2], chan_data[1], chan_data[0]};

  always #5 clk = ~clk;

  seq_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .din       (din),
    .out_ready (out_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_chan  (out_chan)
`ifdef SEQ_MUX_PARITY_EN
    ,
    .dout_par  (dout_par)
`endif
  );

  seq_mux #(.WIDTH(WIDTH), .CHANNELS(3), .DWELL(DWELL)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .din       (din3),
    .out_ready (out_ready),
    .dout      (dout3),
    .out_valid (out_valid3),
    .out_chan  (out_chan3)
`ifdef SEQ_MUX_PARITY_EN
    ,
    .dout_par  (dout_par3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic m, input logic [1:0] s, input logic r);
    en        = e;
    mode      = m;
    sel       = s;
    out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkMain(input string tag, input logic v);
    checkOutput({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    checkOutput({tag, "_chan"}, 32'(out_chan), 32'(exp_chan));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
`ifdef SEQ_MUX_PARITY_EN
    checkOutput({tag, "_par"}, 32'(dout_par), 32'(^exp_dout));
`endif
  endtask

  task automatic randomizeData();
    for (int i = 0; i < 4; i++) chan_data[i] = 8'($urandom);
  endtask

  task automatic loadSpecData();
    chan_data[0] = 8'hAA;
    chan_data[1] = 8'hBB;
    chan_data[2] = 8'hCC;
    chan_data[3] = 8'hDD;
  endtask

  // Runs one dwell period from a fresh count and checks the capture of ch
  task automatic scanChannel(input int ch);
    for (int i = 1; i <= DWELL; i++) begin
      tick();
      if (i == DWELL) begin
        exp_dout = chan_data[ch];
        exp_chan = 2'(ch);
        checkMain($sformatf("scan_cap_ch%0d", ch), 1'b1);
      end else begin
        checkMain($sformatf("scan_dwell_ch%0d", ch), 1'b0);
      end
    end
  endtask

  initial begin
    int s;
    int n;
    int stall;
    logic v;

    // Reset state
    loadSpecData();
    rst = 1'b1;
    applyStimulus(1'b0, MODE_MANUAL, 2'd0, 1'b0);
    tick();
    tick();
    exp_dout = 8'h00;
    exp_chan = 2'd0;
    checkMain("reset", 1'b0);
    checkOutput("reset_dout3", 32'(dout3), 32'h0);
    checkOutput("reset_valid3", 32'(out_valid3), 32'h0);

    // IDLE -> MANUAL, no load on the entry edge
    rst = 1'b0;
    applyStimulus(1'b1, MODE_MANUAL, 2'd0, 1'b0);
    tick();
    checkMain("idle_to_manual", 1'b0);

    // Manual select, one-cycle latency
    sel = 2'd2;
    tick();
    exp_dout = 8'hCC;
    exp_chan = 2'd2;
    checkMain("manual_sel2", 1'b1);
    checkOutput("manual3_sel2_dout", 32'(dout3), 32'hCC);
    sel = 2'd3;
    tick();
    exp_dout = 8'hDD;
    exp_chan = 2'd3;
    checkMain("manual_sel3", 1'b1);
    checkOutput("oor3_dout", 32'(dout3), 32'h00);
    checkOutput("oor3_valid", 32'(out_valid3), 32'h0);
    checkOutput("oor3_chan", 32'(out_chan3), 32'h3);

    // Random manual selections with random data
    for (int it = 0; it < 16; it++) begin
      randomizeData();
      s = int'($urandom_range(0, 3));
      sel = 2'(s);
      tick();
      exp_dout = chan_data[s];
      exp_chan = 2'(s);
      checkMain("manual_rand", 1'b1);
      if (s < 3) begin
        checkOutput("manual3_rand_dout", 32'(dout3), 32'(chan_data[s]));
        checkOutput("manual3_rand_valid", 32'(out_valid3), 32'h1);
      end else begin
        checkOutput("manual3_rand_dout", 32'(dout3), 32'h0);
        checkOutput("manual3_rand_valid", 32'(out_valid3), 32'h0);
      end
    end

`ifdef SEQ_MUX_PARITY_EN
    // Parity of known patterns
    chan_data[1] = 8'hBB;
    sel = 2'd1;
    tick();
    exp_dout = 8'hBB;
    exp_chan = 2'd1;
    checkOutput("par_BB", 32'(dout_par), 32'h0);
    chan_data[1] = 8'hAB;
    tick();
    exp_dout = 8'hAB;
    checkOutput("par_AB", 32'(dout_par), 32'h1);
`endif

    // en low: IDLE, valid cleared, data held
    en = 1'b0;
    tick();
    checkMain("en_low", 1'b0);
    checkOutput("en_low_valid3", 32'(out_valid3), 32'h0);

    // Free-running scan with the consumer always ready
    loadSpecData();
    applyStimulus(1'b1, MODE_SCAN, 2'd0, 1'b1);
    tick();
    checkMain("scan_enter", 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      v = (k >= DWELL) && ((k - DWELL) % (DWELL + 1) == 0);
      if (v) begin
        n = (k - DWELL) / (DWELL + 1);
        exp_dout = chan_data[n % CHANNELS];
        exp_chan = 2'(n % CHANNELS);
      end
      checkMain($sformatf("scan_k%0d", k), v);
    end

    // Backpressure: held samples stay put until accepted
    en = 1'b0;
    tick();
    randomizeData();
    applyStimulus(1'b1, MODE_SCAN, 2'd0, 1'b0);
    tick();
    scanChannel(0);
    stall = int'($urandom_range(2, 6));
    for (int i = 0; i < stall; i++) begin
      tick();
      checkMain("stall_ch0", 1'b1);
    end
    out_ready = 1'b1;
    tick();
    checkMain("accept_ch0", 1'b0);
    out_ready = 1'b0;
    scanChannel(1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkMain("stall10_ch1", 1'b1);
    end
    out_ready = 1'b1;
    tick();
    checkMain("accept_ch1", 1'b0);
    out_ready = 1'b0;
    scanChannel(2);

    // Reset in SCAN_HOLD of ch2, then scan restarts from ch0
    loadSpecData();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_dout = 8'h00;
    exp_chan = 2'd0;
    checkMain("rst_mid_scan", 1'b0);
    checkOutput("rst_mid_scan_dout3", 32'(dout3), 32'h0);
    tick();
    checkMain("rst_rescan_enter", 1'b0);
    scanChannel(0);

    // Mode change from SCAN_HOLD: manual load on the next edge
    sel  = 2'd1;
    mode = MODE_MANUAL;
    tick();
    exp_dout = chan_data[1];
    exp_chan = 2'd1;
    checkMain("scan_to_manual", 1'b1);
    mode = MODE_SCAN;
    tick();
    checkMain("manual_to_scan", 1'b0);
    scanChannel(0);

    // en falling with out_ready high in SCAN_HOLD: en wins
    applyStimulus(1'b0, MODE_SCAN, 2'd0, 1'b1);
    tick();
    checkMain("en_beats_ready", 1'b0);
    applyStimulus(1'b1, MODE_SCAN, 2'd0, 1'b0);
    tick();
    checkMain("rescan_enter", 1'b0);
    scanChannel(0);

    // Random stall lengths across the rest of the channels and the wrap
    for (int ch = 1; ch <= 4; ch++) begin
      stall = int'($urandom_range(0, 4));
      for (int i = 0; i < stall; i++) begin
        tick();
        checkMain("rand_stall", 1'b1);
      end
      out_ready = 1'b1;
      tick();
      checkMain("rand_accept", 1'b0);
      out_ready = 1'b0;
      scanChannel(ch % CHANNELS);
    end

    $display("[TB] stimulus complete");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
